unified_mem_arbiter: RTL and testbench

//  Shares one single-port unified instruction/data memory between the fetch stage (I) and the

---
 rtl/unified_mem_arbiter_if.sv | 41 ++++
 rtl/unified_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch/load-store/memory bus bundle for the unified memory arbiter
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: serves the two requesters and drives the memory.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Environment side: the requesters plus the memory.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-outstanding I/D arbiter for a unified single-port memory
module unified_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 2,
    parameter int FETCH_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW   = (FETCH_MAX < 2) ? 1 : $clog2(FETCH_MAX + 1);

    localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              grant_d;
    logic              grant_i;

    // D wins unless fetch has been passed over FETCH_MAX times in a row.
    always_comb begin
        grant_d = bus.d_req && !(bus.if_req && (starve == STARVE_MAX));
        grant_i = bus.if_req && !grant_d;
    end

    // Transaction FSM: latch the winner in IDLE, strobe memory, wait out latency, pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            cnt        <= '0;
            starve     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        owner   <= OWN_D;
                        addr_q  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                        we_q    <= bus.d_we;
                        wdata_q <= bus.d_wdata;
                        be_q    <= bus.d_we ? bus.d_be : {BE_W{1'b1}};
                        if (bus.if_req && (starve != STARVE_MAX)) begin
                            starve <= starve + 1'b1;
                        end
                        state   <= S_ISSUE;
                    end else if (grant_i) begin
                        owner   <= OWN_I;
                        addr_q  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        we_q    <= 1'b0;
                        be_q    <= {BE_W{1'b1}};
                        starve  <= '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_ONE) begin
                        if (!we_q) begin
                            if (owner == OWN_D) begin
                                d_rdata_q <= bus.mem_rdata;
                            end else begin
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from registered state, so they are clean and X-free after reset.
    assign bus.mem_en    = (state == S_ISSUE);
    assign bus.mem_we    = (state == S_ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_done   = (state == S_RESP) && (owner == OWN_I);
    assign bus.d_done    = (state == S_RESP) && (owner == OWN_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    localparam int MEM_LAT   = 2;
    localparam int FETCH_MAX = 4;
    localparam int LIMIT     = 200;

    typedef struct {
        bit          is_d;
        bit          chk_lat;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_exp_t;

    typedef struct {
        bit          chk_lat;
        logic [31:0] data;
    } rsp_exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } d_cmd_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   i_start  = 0;
    int   d_start  = 0;

    mem_exp_t    exp_mem[$];
    rsp_exp_t    exp_i[$];
    rsp_exp_t    exp_d[$];
    logic [31:0] i_cmd_q[$];
    d_cmd_t      d_cmd_q[$];

    bit [31:0]   mem_arr [1024];
    bit [1023:0] wflag;
    bit [31:0]   pipe_d [MEM_LAT];
    bit          pipe_v [MEM_LAT];

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .FETCH_MAX(FETCH_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %s: observed at cycle %0d, required none", name, cyc);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0050_0093;
            32'h04:  return 32'h0010_0113;
            default: return 32'hA500_0000 | a;
        endcase
    endfunction

    function automatic logic [31:0] word_rd(input logic [31:0] a);
        return wflag[a[11:2]] ? mem_arr[a[11:2]] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Memory model: byte-enabled writes, reads presented for exactly one cycle MEM_LAT after mem_en.
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
            mem_arr[bus.mem_addr[11:2]] <= merge(word_rd(bus.mem_addr), bus.mem_wdata, bus.mem_be);
            wflag[bus.mem_addr[11:2]]   <= 1'b1;
        end
        pipe_v[0] <= (bus.mem_en === 1'b1) && (bus.mem_we !== 1'b1);
        pipe_d[0] <= word_rd(bus.mem_addr);
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign bus.mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hBAD0_BAD0;

    // Fetch requester: holds if_req across back-to-back commands, drops it when out of work.
    initial begin : i_driver
        int n;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        forever begin
            while (i_cmd_q.size() == 0) begin @(posedge clk); #1; end
            bus.if_addr = i_cmd_q.pop_front();
            bus.if_req  = 1'b1;
            i_start     = cyc;
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (bus.if_done === 1'b1 || !reset || n > LIMIT) break;
            end
            if (!reset) begin
                bus.if_req = 1'b0;
            end else begin
                if (n > LIMIT) fail_evt("if_done timeout");
                @(posedge clk); #1;
                if (i_cmd_q.size() == 0) bus.if_req = 1'b0;
            end
        end
    end

    // Load/store requester, same protocol as the fetch side.
    initial begin : d_driver
        int n;
        d_cmd_t c;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
        forever begin
            while (d_cmd_q.size() == 0) begin @(posedge clk); #1; end
            c = d_cmd_q.pop_front();
            bus.d_we    = c.we;
            bus.d_addr  = c.addr;
            bus.d_wdata = c.wdata;
            bus.d_be    = c.be;
            bus.d_req   = 1'b1;
            d_start     = cyc;
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (bus.d_done === 1'b1 || !reset || n > LIMIT) break;
            end
            if (!reset) begin
                bus.d_req = 1'b0;
            end else begin
                if (n > LIMIT) fail_evt("d_done timeout");
                @(posedge clk); #1;
                if (d_cmd_q.size() == 0) bus.d_req = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes memory or pulses a done.
    initial begin : monitor
        mem_exp_t m;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) begin
                if (exp_mem.size() == 0) begin
                    fail_evt("unexpected mem_en");
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", bus.mem_addr, m.addr);
                    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, m.we});
                    chk("mem_be", {28'b0, bus.mem_be}, {28'b0, m.be});
                    if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
                    if (m.chk_lat) chk("mem_en cycle", 32'(cyc), 32'((m.is_d ? d_start : i_start) + 1));
                end
            end else if (bus.mem_we !== 1'b0) begin
                fail_evt("mem_we without mem_en");
            end
            if (bus.if_done === 1'b1) begin
                if (exp_i.size() == 0) begin
                    fail_evt("unexpected if_done");
                end else begin
                    r = exp_i.pop_front();
                    chk("if_rdata", bus.if_rdata, r.data);
                    if (r.chk_lat) chk("if_done cycle", 32'(cyc), 32'(i_start + MEM_LAT + 2));
                end
            end
            if (bus.d_done === 1'b1) begin
                if (exp_d.size() == 0) begin
                    fail_evt("unexpected d_done");
                end else begin
                    r = exp_d.pop_front();
                    chk("d_rdata", bus.d_rdata, r.data);
                    if (r.chk_lat) chk("d_done cycle", 32'(cyc), 32'(d_start + MEM_LAT + 2));
                end
            end
        end
    end

    function automatic void x_mem(input bit is_d, input bit lat, input bit we,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        mem_exp_t m;
        m.is_d = is_d; m.chk_lat = lat; m.we = we; m.addr = a; m.wdata = wd; m.be = be;
        exp_mem.push_back(m);
    endfunction

    function automatic void q_fetch(input logic [31:0] a, input logic [31:0] data, input bit lat);
        rsp_exp_t r;
        r.chk_lat = lat; r.data = data;
        exp_i.push_back(r);
        i_cmd_q.push_back(a);
    endfunction

    function automatic void q_d(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input logic [31:0] rdata, input bit lat);
        rsp_exp_t r;
        d_cmd_t c;
        r.chk_lat = lat; r.data = rdata;
        c.we = we; c.addr = a; c.wdata = wd; c.be = be;
        exp_d.push_back(r);
        d_cmd_q.push_back(c);
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_mem.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0 ||
                i_cmd_q.size() != 0 || d_cmd_q.size() != 0 ||
                bus.if_req !== 1'b0 || bus.d_req !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_evt({name, " drain timeout"});
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int quiet;
        int n;

        // Reset state with requests idle, then a quiet interval after release.
        repeat (2) @(negedge clk);
        chk("rst if_done",   {31'b0, bus.if_done}, 32'h0);
        chk("rst d_done",    {31'b0, bus.d_done},  32'h0);
        chk("rst mem_en",    {31'b0, bus.mem_en},  32'h0);
        chk("rst mem_we",    {31'b0, bus.mem_we},  32'h0);
        chk("rst mem_addr",  bus.mem_addr,         32'h0);
        chk("rst mem_wdata", bus.mem_wdata,        32'h0);
        chk("rst mem_be",    {28'b0, bus.mem_be},  32'h0);
        chk("rst if_rdata",  bus.if_rdata,         32'h0);
        chk("rst d_rdata",   bus.d_rdata,          32'h0);
        reset = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_en !== 1'b0) quiet++;
        end
        chk("mem_en quiet after reset", 32'(quiet), 32'h0);

        // Lone fetch with exact latency.
        x_mem(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        q_fetch(32'h10, 32'h0050_0093, 1'b1);
        wait_idle("fetch");

        // Simultaneous fetch and store: D first, then I.
        x_mem(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        x_mem(1'b0, 1'b0, 1'b0, 32'h20,  32'h0,         4'hF);
        q_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        q_fetch(32'h20, 32'hA500_0020, 1'b0);
        wait_idle("contend");

        // Misaligned partial store, then loads/stores showing d_rdata only moves on loads.
        x_mem(1'b1, 1'b1, 1'b1, 32'h100, 32'h0000_AB00, 4'h2);
        q_d(1'b1, 32'h103, 32'h0000_AB00, 4'h2, 32'h0, 1'b1);
        wait_idle("partial store");
        x_mem(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        q_d(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b1);
        wait_idle("load");
        x_mem(1'b1, 1'b0, 1'b1, 32'h104, 32'h1122_3344, 4'hF);
        q_d(1'b1, 32'h104, 32'h1122_3344, 4'hF, 32'hDEAD_ABEF, 1'b0);
        wait_idle("store keeps d_rdata");
        x_mem(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
        q_d(1'b0, 32'h106, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
        wait_idle("misaligned load");

        // Starvation guard: D,D,D,D,I,D,D,D,D,I,D.
        for (int k = 0; k < 4; k++) x_mem(1'b1, 1'b0, 1'b0, 32'h300 + 32'(4*k), 32'h0, 4'hF);
        x_mem(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 4'hF);
        for (int k = 4; k < 8; k++) x_mem(1'b1, 1'b0, 1'b0, 32'h300 + 32'(4*k), 32'h0, 4'hF);
        x_mem(1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 4'hF);
        x_mem(1'b1, 1'b0, 1'b0, 32'h320, 32'h0, 4'hF);
        for (int k = 0; k < 9; k++) q_d(1'b0, 32'h300 + 32'(4*k), 32'h0, 4'h0, 32'hA500_0300 + 32'(4*k), 1'b0);
        q_fetch(32'h200, 32'hA500_0200, 1'b0);
        q_fetch(32'h204, 32'hA500_0204, 1'b0);
        wait_idle("starve");

        // Reset during WAIT aborts the fetch silently; a later fetch completes normally.
        x_mem(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        i_cmd_q.push_back(32'h40);
        n = 0;
        while (exp_mem.size() != 0 && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) fail_evt("abort fetch never issued");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid reset mem_en",  {31'b0, bus.mem_en},  32'h0);
        chk("mid reset if_done", {31'b0, bus.if_done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("if_rdata after abort", bus.if_rdata, 32'h0);
        x_mem(1'b0, 1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
        q_fetch(32'h04, 32'h0010_0113, 1'b1);
        wait_idle("post-reset fetch");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
